// File: rtl/alu_exec_pkg.sv
// Shared encodings for the ALU execute sequencer: FSM states, instruction
// field positions, common ALU control words and the jump-condition helper.
package alu_exec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MEM_RD = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_t;

   localparam int TYPE_B  = 15;
   localparam int YSEL_B  = 14;
   localparam int CTL_MSB = 13;
   localparam int CTL_LSB = 8;
   localparam int DST_A   = 7;
   localparam int DST_D   = 6;
   localparam int DST_M   = 5;
   localparam int JMP_LT  = 4;
   localparam int JMP_EQ  = 3;
   localparam int JMP_GT  = 2;

   localparam logic [5:0] CTL_ZERO      = 6'b101010;
   localparam logic [5:0] CTL_Y         = 6'b110000;
   localparam logic [5:0] CTL_X_MINUS_Y = 6'b010011;
   localparam logic [5:0] CTL_Y_PLUS1   = 6'b110111;

   // jmp is {lt, eq, gt}; gt means strictly positive (neither zero nor negative)
   function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
      return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/alu_jump_eval.sv
// Combinational jump-condition evaluation from the {lt,eq,gt} jump bits
// and the zero/negative flags of the ALU result.
module alu_jump_eval
   import alu_exec_pkg::*;
(
   input  logic [2:0] jump,
   input  logic       zr,
   input  logic       ng,
   output logic       pc_cond
);

   assign pc_cond = jump_taken(jump, zr, ng);

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute sequencer around an external zx/nx/zy/ny/f/no ALU: IDLE -> [MEM_RD] -> EXEC -> WB.
// Optional MEM_TIMEOUT_EN bounds the MEM_RD wait to TMO_CYC+1 cycles and pulses err on expiry.
module alu_exec_ctrl
   import alu_exec_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TMO_CYC = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   instr,
   output logic [DW-1:0] alu_x,
   output logic [DW-1:0] alu_y,
   output logic [5:0]    alu_ctl,
   input  logic [DW-1:0] alu_o,
   input  logic          alu_zr,
   input  logic          alu_ng,
   output logic [DW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata,
   output logic          pc_load,
   output logic [DW-1:0] pc_target,
   output logic          zr_q,
   output logic          ng_q,
   output logic          err
);

   state_t        r_state;
   state_t        w_next;
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_d;
   logic [DW-1:0] r_m;
   logic [DW-1:0] r_res;
   logic          r_zr;
   logic          r_ng;
   logic          r_ysel;
   logic [5:0]    r_ctl;
   logic [2:0]    r_dest;
   logic [2:0]    r_jmp;
   logic          r_mem_rd;
   logic          r_mem_wr;
   logic          r_pc_load;
   logic          w_accept;
   logic          w_jump_ok;
   logic          w_tmo_hit;

`ifdef MEM_TIMEOUT_EN
   localparam logic [3:0] TMO_LIM = 4'(TMO_CYC);
   logic [3:0] r_tmo;
   logic       r_err;
   assign w_tmo_hit = (r_tmo == TMO_LIM);
   assign err       = r_err;
`else
   assign w_tmo_hit = 1'b0;
   assign err       = 1'b0;
`endif

   assign w_accept    = (r_state == ST_IDLE) & instr_valid;
   assign instr_ready = (r_state == ST_IDLE);
   assign alu_x       = r_d;
   assign alu_y       = r_ysel ? r_m : r_a;
   assign alu_ctl     = r_ctl;
   assign mem_addr    = r_a;
   assign mem_wdata   = r_res;
   assign pc_target   = r_a;
   assign mem_rd      = r_mem_rd;
   assign mem_wr      = r_mem_wr;
   assign pc_load     = r_pc_load;
   assign zr_q        = r_zr;
   assign ng_q        = r_ng;

   alu_jump_eval u_jump (
      .jump    (r_jmp),
      .zr      (alu_zr),
      .ng      (alu_ng),
      .pc_cond (w_jump_ok)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && instr[TYPE_B]) begin
               w_next = instr[YSEL_B] ? ST_MEM_RD : ST_EXEC;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_MEM_RD: begin
            if (mem_rvalid) begin
               w_next = ST_EXEC;
            end else if (w_tmo_hit) begin
               w_next = ST_IDLE;
            end else begin
               w_next = ST_MEM_RD;
            end
         end
         ST_EXEC: w_next = ST_WB;
         ST_WB:   w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Datapath registers and one-cycle strobes; strobes are armed one state early so they are registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a       <= '0;
         r_d       <= '0;
         r_m       <= '0;
         r_res     <= '0;
         r_zr      <= 1'b0;
         r_ng      <= 1'b0;
         r_ysel    <= 1'b0;
         r_ctl     <= 6'b000000;
         r_dest    <= 3'b000;
         r_jmp     <= 3'b000;
         r_mem_rd  <= 1'b0;
         r_mem_wr  <= 1'b0;
         r_pc_load <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_tmo     <= 4'd0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_mem_rd  <= 1'b0;
         r_mem_wr  <= 1'b0;
         r_pc_load <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_err     <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (instr[TYPE_B]) begin
                     r_ysel   <= instr[YSEL_B];
                     r_ctl    <= instr[CTL_MSB:CTL_LSB];
                     r_dest   <= instr[DST_A:DST_M];
                     r_jmp    <= instr[JMP_LT:JMP_GT];
                     r_mem_rd <= instr[YSEL_B];
`ifdef MEM_TIMEOUT_EN
                     r_tmo    <= 4'd0;
`endif
                  end else begin
                     r_a <= instr[DW-1:0];
                  end
               end
            end
            ST_MEM_RD: begin
               if (mem_rvalid) begin
                  r_m <= mem_rdata;
`ifdef MEM_TIMEOUT_EN
               end else if (w_tmo_hit) begin
                  r_err <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + 4'd1;
`endif
               end
            end
            ST_EXEC: begin
               r_res     <= alu_o;
               r_zr      <= alu_zr;
               r_ng      <= alu_ng;
               r_mem_wr  <= r_dest[0];
               r_pc_load <= w_jump_ok;
            end
            ST_WB: begin
               if (r_dest[2]) begin
                  r_a <= r_res;
               end
               if (r_dest[1]) begin
                  r_d <= r_res;
               end
            end
            default: begin
               r_a <= r_a;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Table-driven bench for alu_exec_ctrl with a behavioural ALU and hand-driven memory responses.
module tb_alu_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = 16'h0000;
   logic [7:0]  alu_x, alu_y, alu_o;
   logic [5:0]  alu_ctl;
   logic        alu_zr, alu_ng;
   logic [7:0]  mem_addr, mem_wdata, pc_target;
   logic        mem_rd, mem_wr, pc_load, zr_q, ng_q, err;
   logic        mem_rvalid = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;

   int checks = 0;
   int failures = 0;
   int n_pc = 0, n_wr = 0, n_rd = 0, n_err = 0;
   logic [7:0] last_tgt = 8'h00, wr_addr = 8'h00, wr_data = 8'h00;

   alu_exec_ctrl #(.DW(8), .TMO_CYC(15)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .pc_load(pc_load), .pc_target(pc_target),
      .zr_q(zr_q), .ng_q(ng_q), .err(err)
   );

   always #5 clk = ~clk;

   // Reference zx/nx/zy/ny/f/no ALU
   always_comb begin
      logic [7:0] x, y, o;
      x = alu_ctl[5] ? 8'h00 : alu_x;
      x = alu_ctl[4] ? ~x : x;
      y = alu_ctl[3] ? 8'h00 : alu_y;
      y = alu_ctl[2] ? ~y : y;
      o = alu_ctl[1] ? (x + y) : (x & y);
      o = alu_ctl[0] ? ~o : o;
      alu_o  = o;
      alu_zr = (o == 8'h00);
      alu_ng = o[7];
   end

   always @(negedge clk) begin
      if (pc_load) begin n_pc <= n_pc + 1; last_tgt <= pc_target; end
      if (mem_wr)  begin n_wr <= n_wr + 1; wr_addr <= mem_addr; wr_data <= mem_wdata; end
      if (mem_rd)  n_rd <= n_rd + 1;
      if (err)     n_err <= n_err + 1;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] ins);
      @(negedge clk);
      for (int g = 0; g < 50 && !instr_ready; g++) @(negedge clk);
      chk("ready_before_send", {15'd0, instr_ready}, 16'd1);
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!instr_ready && cyc < 50);
   endtask

   typedef struct {
      logic [15:0] ins;
      logic [7:0]  a;
      logic [7:0]  d;
      logic        zr;
      logic        ng;
      int          npc;
      logic [7:0]  tgt;
      int          cyc;
   } vec_t;

   vec_t vt[12];

   initial begin
      int cyc, p0, w0, r0, cnt, exp_err;
      logic seen;

      vt[0]  = '{16'h0005, 8'h05, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1};
      vt[1]  = '{16'hB040, 8'h05, 8'h05, 1'b0, 1'b0, 0, 8'h00, 3};
      vt[2]  = '{16'h0003, 8'h03, 8'h05, 1'b0, 1'b0, 0, 8'h00, 1};
      vt[3]  = '{16'h9340, 8'h03, 8'h02, 1'b0, 1'b0, 0, 8'h00, 3};
      vt[4]  = '{16'h9310, 8'h03, 8'h02, 1'b0, 1'b1, 1, 8'h03, 3};
      vt[5]  = '{16'hAA48, 8'h03, 8'h00, 1'b1, 1'b0, 1, 8'h03, 3};
      vt[6]  = '{16'hB784, 8'h04, 8'h00, 1'b0, 1'b0, 1, 8'h03, 3};
      vt[7]  = '{16'h00FF, 8'hFF, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1};
      vt[8]  = '{16'hB7C8, 8'h00, 8'h00, 1'b1, 1'b0, 1, 8'hFF, 3};
      vt[9]  = '{16'h0007, 8'h07, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1};
      vt[10] = '{16'h9344, 8'h07, 8'hF9, 1'b0, 1'b1, 0, 8'h00, 3};
      vt[11] = '{16'hB01C, 8'h07, 8'hF9, 1'b0, 1'b0, 1, 8'h07, 3};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {15'd0, instr_ready}, 16'd1);
      chk("rst_a", {8'd0, mem_addr}, 16'h0000);
      chk("rst_d", {8'd0, alu_x}, 16'h0000);
      chk("rst_flags", {14'd0, zr_q, ng_q}, 16'd0);
      chk("rst_strobes", {12'd0, mem_rd, mem_wr, pc_load, err}, 16'd0);

      for (int i = 0; i < 12; i++) begin
         p0 = n_pc;
         send(vt[i].ins);
         if (!vt[i].ins[15]) chk($sformatf("v%0d_ready_atype", i), {15'd0, instr_ready}, 16'd1);
         if (!vt[i].ins[15]) chk($sformatf("v%0d_a_next_edge", i), {8'd0, mem_addr}, {8'd0, vt[i].a});
         wait_idle(cyc);
         chk($sformatf("v%0d_cycles", i), 16'(cyc), 16'(vt[i].cyc));
         chk($sformatf("v%0d_a", i), {8'd0, mem_addr}, {8'd0, vt[i].a});
         chk($sformatf("v%0d_d", i), {8'd0, alu_x}, {8'd0, vt[i].d});
         chk($sformatf("v%0d_zr_ng", i), {14'd0, zr_q, ng_q}, {14'd0, vt[i].zr, vt[i].ng});
         chk($sformatf("v%0d_pc_pulses", i), 16'(n_pc - p0), 16'(vt[i].npc));
         if (vt[i].npc != 0) chk($sformatf("v%0d_pc_target", i), {8'd0, last_tgt}, {8'd0, vt[i].tgt});
      end

      // M-operand read with dest A+M: write goes to old A, A takes result afterwards
      send(16'h0010);
      wait_idle(cyc);
      p0 = n_pc; w0 = n_wr; r0 = n_rd;
      send(16'hF7A0);
      repeat (3) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata = 8'h7F;
      @(negedge clk);
      mem_rvalid = 1'b0;
      wait_idle(cyc);
      chk("m_rd_pulses", 16'(n_rd - r0), 16'd1);
      chk("m_wr_pulses", 16'(n_wr - w0), 16'd1);
      chk("m_wr_addr", {8'd0, wr_addr}, 16'h0010);
      chk("m_wr_data", {8'd0, wr_data}, 16'h0080);
      chk("m_ng", {15'd0, ng_q}, 16'd1);
      chk("m_a_after", {8'd0, mem_addr}, 16'h0080);
      chk("m_d_kept", {8'd0, alu_x}, 16'h00F9);
      chk("m_no_jump", 16'(n_pc - p0), 16'd0);

      // Stray rvalid in IDLE is ignored
      mem_rvalid = 1'b1;
      mem_rdata = 8'h55;
      @(negedge clk);
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("stray_rvalid_ready", {15'd0, instr_ready}, 16'd1);
      chk("stray_rvalid_a", {8'd0, mem_addr}, 16'h0080);

      // Reset during MEM_RD abandons the instruction
      send(16'h0022);
      wait_idle(cyc);
      p0 = n_pc; w0 = n_wr;
      send(16'hF7BC);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_ready", {15'd0, instr_ready}, 16'd1);
      chk("rst_mid_a", {8'd0, mem_addr}, 16'h0000);
      chk("rst_mid_d", {8'd0, alu_x}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 8'h7F;
      @(negedge clk);
      mem_rvalid = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mid_no_wr", 16'(n_wr - w0), 16'd0);
      chk("rst_mid_no_pc", 16'(n_pc - p0), 16'd0);
      chk("rst_mid_ready_after", {15'd0, instr_ready}, 16'd1);
      chk("rst_mid_a_after", {8'd0, mem_addr}, 16'h0000);

`ifdef MEM_TIMEOUT_EN
      send(16'h0009);
      wait_idle(cyc);
      send(16'hB040);
      wait_idle(cyc);
      send(16'h0033);
      wait_idle(cyc);
      p0 = n_pc; w0 = n_wr;
      send(16'hF7BC);
      cnt = 0;
      seen = 1'b0;
      for (int g = 0; g < 40; g++) begin
         @(negedge clk);
         if (err) begin
            seen = 1'b1;
            break;
         end
         if (!instr_ready) cnt++;
      end
      chk("tmo_err_seen", {15'd0, seen}, 16'd1);
      chk("tmo_mem_rd_cycles", 16'(cnt), 16'd16);
      chk("tmo_ready", {15'd0, instr_ready}, 16'd1);
      @(negedge clk);
      chk("tmo_err_width", {15'd0, err}, 16'd0);
      chk("tmo_a_kept", {8'd0, mem_addr}, 16'h0033);
      chk("tmo_d_kept", {8'd0, alu_x}, 16'h0009);
      chk("tmo_no_wr", 16'(n_wr - w0), 16'd0);
      chk("tmo_no_pc", 16'(n_pc - p0), 16'd0);
      send(16'h0044);
      chk("tmo_next_accept", {8'd0, mem_addr}, 16'h0044);
      exp_err = 1;
`else
      exp_err = 0;
`endif
      @(negedge clk);
      chk("err_pulses", 16'(n_err), 16'(exp_err));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
